alu_op_sequencer: RTL

- Multi-cycle controller that sequences the team's 4-bit, 8-operation ALU (Decode_And_Execute) against a 4-entry x 4-bit register file that this block owns.
- Accepts one encoded instruction at a time over a valid/ready handshake, then walks IDLE -> DECODE -> EXEC -> WB: read operands, drive the external ALU, write back, report.
- Also provides a host write/read port for loading and inspecting registers, plus a retired-instruction counter.

---
 rtl/alu_op_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Multi-cycle controller for the external 4-bit, 8-operation ALU. It owns a
// 4 x 4-bit register file. It accepts one instruction at a time and walks
// IDLE -> DECODE -> EXEC -> WB. In DECODE it reads the operands, in EXEC it
// captures the ALU result, and in WB it writes the result back and reports it.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   in_valid/in_ready      instruction handshake (ready only in IDLE)
//   in_instr[8:0]          {op[8:6], rd[5:4], rs[3:2], rt[1:0]}
//   alu_rs/alu_rt/alu_sel  registered operands and opcode to the external ALU
//   alu_rd                 combinational result from the external ALU
//   host_we/addr/wdata     host register write, honoured only in IDLE
//   dbg_addr/dbg_data      combinational register read port
//   done                   one-cycle pulse during WB
//   result                 last written-back value
//   retired                count of completed instructions (wraps)
module alu_op_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       in_instr,
  output logic [3:0]       alu_rs,
  output logic [3:0]       alu_rt,
  output logic [2:0]       alu_sel,
  input  logic [3:0]       alu_rd,
  input  logic             host_we,
  input  logic [1:0]       host_addr,
  input  logic [3:0]       host_wdata,
  input  logic [1:0]       dbg_addr,
  output logic [3:0]       dbg_data,
  output logic             done,
  output logic [3:0]       result,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t           state, next_state;
  logic [8:0]       instr_q;
  logic [3:0]       regs [4];
  logic [3:0]       result_q;
  logic [CNT_W-1:0] retired_q;

  logic [2:0] op;
  logic [1:0] rd, rs, rt;
  logic       accept;

  assign op     = instr_q[8:6];
  assign rd     = instr_q[5:4];
  assign rs     = instr_q[3:2];
  assign rt     = instr_q[1:0];
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = DECODE;
      end
      DECODE: next_state = EXEC;
      EXEC:   next_state = WB;
      WB: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The result is captured at the end of EXEC, so it is already visible
  // during WB. It then holds until the next instruction reaches WB.
  // A host write and a WB write can never collide, because the host port
  // is only open in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      alu_rs    <= '0;
      alu_rt    <= '0;
      alu_sel   <= '0;
      result_q  <= '0;
      retired_q <= '0;
    end else begin
      if (state == IDLE && host_we) regs[host_addr] <= host_wdata;
      if (accept) instr_q <= in_instr;
      if (state == DECODE) begin
        alu_rs  <= regs[rs];
        alu_rt  <= regs[rt];
        alu_sel <= op;
      end
      if (state == EXEC) result_q <= alu_rd;
      if (state == WB) begin
        regs[rd]  <= result_q;
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign dbg_data = regs[dbg_addr];
  assign result   = result_q;
  assign retired  = retired_q;

endmodule
